// File: rtl/fp_div_unit.sv
// fp_div_unit: IEEE754 single-precision divider (data1/data2).
// Restoring mantissa division, one quotient bit per cycle, then a single
// normalize/round-to-nearest-even stage. Denormal operands flush to zero.
module fp_div_unit #(
    parameter int QBITS = 26
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        sel_div,
    input  logic [31:0] data1_in,
    input  logic [31:0] data2_in,
    output logic [31:0] div_result_out,
    output logic        div_vld_out,
    output logic        div_busy
);

    localparam int CW = $clog2(QBITS);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ITER,
        NORM_RND,
        DONE
    } state_t;

    state_t r_state, w_next;

    logic [31:0]        r_a, r_b;
    logic               r_sign;
    logic [31:0]        r_spec;
    logic [23:0]        r_mb;
    logic [24:0]        r_rem;
    logic [QBITS-1:0]   r_q;
    logic signed [9:0]  r_exp;
    logic [CW-1:0]      r_cnt;
    logic [31:0]        r_result;
    logic               r_vld;

    // ---------------- operand classification ----------------
    logic [7:0]  w_e1, w_e2;
    logic [22:0] w_f1, w_f2;
    logic        w_sign;
    logic        w_nan1, w_nan2, w_inf1, w_inf2, w_zero1, w_zero2;
    logic        w_special;
    logic [31:0] w_spec_res;

    assign w_e1    = r_a[30:23];
    assign w_e2    = r_b[30:23];
    assign w_f1    = r_a[22:0];
    assign w_f2    = r_b[22:0];
    assign w_sign  = r_a[31] ^ r_b[31];
    assign w_nan1  = (w_e1 == 8'hFF) && (w_f1 != 23'd0);
    assign w_nan2  = (w_e2 == 8'hFF) && (w_f2 != 23'd0);
    assign w_inf1  = (w_e1 == 8'hFF) && (w_f1 == 23'd0);
    assign w_inf2  = (w_e2 == 8'hFF) && (w_f2 == 23'd0);
    // exponent zero covers both true zero and denormals (flushed)
    assign w_zero1 = (w_e1 == 8'h00);
    assign w_zero2 = (w_e2 == 8'h00);
    assign w_special = w_nan1 | w_nan2 | w_inf1 | w_inf2 | w_zero1 | w_zero2;

    // special-result selection, highest priority first
    always_comb begin
        w_spec_res = {w_sign, 31'd0};
        if (w_nan1 || w_nan2)
            w_spec_res = 32'h7FC0_0000;
        else if ((w_inf1 && w_inf2) || (w_zero1 && w_zero2))
            w_spec_res = 32'h7FC0_0000;
        else if (w_inf1 || w_zero2)
            w_spec_res = {w_sign, 8'hFF, 23'd0};
        else
            w_spec_res = {w_sign, 31'd0};
    end

    // ---------------- restoring division step ----------------
    logic        w_ge;
    logic [23:0] w_diff;
    logic [24:0] w_rem_nxt;

    assign w_ge      = (r_rem >= {1'b0, r_mb});
    // after a subtract the remainder is below mb, so 24 bits suffice
    assign w_diff    = w_ge ? (r_rem[23:0] - r_mb) : r_rem[23:0];
    assign w_rem_nxt = {w_diff, 1'b0};

    // ---------------- normalize and round ----------------
    logic [QBITS-1:0]  w_qn;
    logic signed [9:0] w_exp_n, w_exp_r;
    logic [23:0]       w_mant;
    logic              w_guard, w_sticky, w_rup, w_carry;
    logic [22:0]       w_frac;
    logic [31:0]       w_norm_res;

    // quotient below 1.0 gets one left shift so its leading one is the MSB
    assign w_qn     = r_q[QBITS-1] ? r_q : {r_q[QBITS-2:0], 1'b0};
    assign w_exp_n  = r_q[QBITS-1] ? r_exp : (r_exp - 10'sd1);
    assign w_mant   = w_qn[QBITS-1 -: 24];
    assign w_guard  = w_qn[QBITS-25];
    assign w_sticky = (|w_qn[QBITS-26:0]) | (|r_rem);
    assign w_rup    = w_guard & (w_sticky | w_mant[0]);
    // an all-ones mantissa rounding up wraps the fraction to 1.0
    assign w_carry  = w_rup & (&w_mant);
    assign w_frac   = w_mant[22:0] + {22'd0, w_rup};
    assign w_exp_r  = w_carry ? (w_exp_n + 10'sd1) : w_exp_n;

    // range check of the final exponent
    always_comb begin
        w_norm_res = {r_sign, w_exp_r[7:0], w_frac};
        if (w_exp_r >= 10'sd255)
            w_norm_res = {r_sign, 8'hFF, 23'd0};
        else if (w_exp_r <= 10'sd0)
            w_norm_res = {r_sign, 31'd0};
    end

    // ---------------- control ----------------
    // state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    // next-state logic; sel_div only matters in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (sel_div) w_next = UNPACK;
            UNPACK:   w_next = w_special ? DONE : ITER;
            ITER:     if (r_cnt == CW'(QBITS-1)) w_next = NORM_RND;
            NORM_RND: w_next = IDLE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // datapath registers, advanced according to the current state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sign   <= 1'b0;
            r_spec   <= '0;
            r_mb     <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_exp    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_vld    <= 1'b0;
        end else begin
            r_vld <= (r_state == NORM_RND) || (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (sel_div) begin
                        r_a <= data1_in;
                        r_b <= data2_in;
                    end
                end
                UNPACK: begin
                    r_sign <= w_sign;
                    r_spec <= w_spec_res;
                    r_mb   <= {1'b1, w_f2};
                    r_rem  <= {2'b01, w_f1};
                    r_exp  <= $signed({2'b00, w_e1}) - $signed({2'b00, w_e2}) + 10'sd127;
                    r_cnt  <= '0;
                    r_q    <= '0;
                end
                ITER: begin
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
                NORM_RND: r_result <= w_norm_res;
                DONE:     r_result <= r_spec;
                default: ;
            endcase
        end
    end

    assign div_result_out = r_result;
    assign div_vld_out    = r_vld;
    assign div_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fp_div_unit.sv
// tb_fp_div_unit: directed vectors against fp_div_unit with an
// arithmetic reference model and a per-cycle output compare.
module tb_fp_div_unit;

    localparam int QB = 26;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        sel_div = 1'b0;
    logic [31:0] data1_in = '0;
    logic [31:0] data2_in = '0;
    logic [31:0] div_result_out;
    logic        div_vld_out;
    logic        div_busy;

    int checks = 0;
    int errors = 0;

    fp_div_unit #(.QBITS(QB)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sel_div(sel_div),
        .data1_in(data1_in), .data2_in(data2_in),
        .div_result_out(div_result_out), .div_vld_out(div_vld_out), .div_busy(div_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit is_spec(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    // Reference: exact integer quotient of the mantissas, then IEEE RNE.
    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        longint unsigned ma, mb, num, q, r, mant, rest, half;
        logic [7:0] e8;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if ((ea == 255 && eb == 255) || (ea == 0 && eb == 0)) return 32'h7FC00000;
        if (ea == 255 || eb == 0) return {s, 8'hFF, 23'd0};
        if (ea == 0 || eb == 255) return {s, 31'd0};
        ma  = {40'd0, 1'b1, a[22:0]};
        mb  = {40'd0, 1'b1, b[22:0]};
        num = ma << (QB - 1);
        q   = num / mb;
        r   = num % mb;
        e   = ea - eb + 127;
        if (q >= (64'd1 << (QB - 1))) sh = QB - 24;
        else begin sh = QB - 25; e = e - 1; end
        mant = q >> sh;
        rest = q & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (rest > half || (rest == half && (r != 0 || mant[0]))) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e = e + 1; end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        e8 = e[7:0];
        return {s, e8, mant[22:0]};
    endfunction

    // cycle-level expectation: in flight, cycles left, pending and last result
    logic        m_active = 1'b0;
    logic        m_vld = 1'b0;
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_last = '0;

    // model advance on each edge; reset wipes it like the DUT
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_active <= 1'b0; m_vld <= 1'b0; m_left <= 0; m_pend <= '0; m_last <= '0;
        end else begin
            m_vld <= m_active && (m_left == 1);
            if (m_active && m_left == 1) m_last <= m_pend;
            if (!m_active && sel_div) begin
                m_active <= 1'b1;
                m_left   <= is_spec(data1_in, data2_in) ? 2 : QB + 2;
                m_pend   <= model_div(data1_in, data2_in);
            end else if (m_active) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_active <= 1'b0;
            end
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge sys_clk) begin
        chk("vld", {31'd0, div_vld_out}, {31'd0, m_vld});
        chk("busy", {31'd0, div_busy}, {31'd0, m_active});
        chk("result", div_result_out, m_last);
    end

    // issue one divide; wait for vld, check latency and value
    task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input int lat, input int extra_k, input bit now, input string nm);
        bit seen = 0;
        int k;
        chk({nm, " model"}, model_div(a, b), exp);
        if (!now) @(negedge sys_clk);
        sel_div = 1'b1; data1_in = a; data2_in = b;
        for (k = 0; k < 60; k++) begin
            @(negedge sys_clk);
            sel_div = (k == extra_k);
            if (k == extra_k) begin data1_in = 32'h3F800000; data2_in = 32'h40400000; end
            if (div_vld_out) begin seen = 1; break; end
        end
        if (!seen) begin
            errors++; checks++;
            $display("FAIL %s timeout: got no vld expected vld within 60 cycles", nm);
        end else begin
            chk({nm, " latency"}, 32'(k), 32'(lat));
            chk({nm, " value"}, div_result_out, exp);
        end
    endtask

    initial begin
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset result", div_result_out, 32'h0);
        chk("reset vld", {31'd0, div_vld_out}, 32'd0);
        chk("reset busy", {31'd0, div_busy}, 32'd0);
        #2 sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        run_vec(32'h40C00000, 32'h40000000, 32'h40400000, 28, -1, 0, "6/2");
        run_vec(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, -1, 0, "1/3");
        run_vec(32'h3F800000, 32'h3F800000, 32'h3F800000, 28, -1, 0, "1/1");
        run_vec(32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 28, -1, 0, "1/1.5");
        run_vec(32'h3F800000, 32'h00000000, 32'h7F800000, 2, -1, 0, "1/0");
        run_vec(32'hBF800000, 32'h00000000, 32'hFF800000, 2, -1, 0, "-1/0");
        run_vec(32'h00000000, 32'h00000000, 32'h7FC00000, 2, -1, 0, "0/0");
        run_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2, -1, 0, "nan/1");
        run_vec(32'h80000000, 32'h40000000, 32'h80000000, 2, -1, 0, "-0/2");
        run_vec(32'h00000001, 32'h3F800000, 32'h00000000, 2, -1, 0, "denorm/1");
        run_vec(32'h7F800000, 32'h7F800000, 32'h7FC00000, 2, -1, 0, "inf/inf");
        run_vec(32'h40000000, 32'hFF800000, 32'h80000000, 2, -1, 0, "2/-inf");
        run_vec(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 28, -1, 0, "overflow");
        run_vec(32'h00800000, 32'h40000000, 32'h00000000, 28, -1, 0, "underflow");
        run_vec(32'hC1200000, 32'h40800000, 32'hC0200000, 28, -1, 0, "-10/4");
        // second select mid-operation must be ignored
        run_vec(32'h40C00000, 32'h40000000, 32'h40400000, 28, 4, 0, "ignore sel");
        // back-to-back: new select while vld is high
        run_vec(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, -1, 0, "chain a");
        run_vec(32'h40C00000, 32'h40000000, 32'h40400000, 28, -1, 1, "chain b");

        // reset mid-operation: outputs clear at once, no vld afterwards
        @(negedge sys_clk);
        sel_div = 1'b1; data1_in = 32'h40C00000; data2_in = 32'h40000000;
        @(negedge sys_clk);
        sel_div = 1'b0;
        repeat (9) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("abort result", div_result_out, 32'h0);
        chk("abort vld", {31'd0, div_vld_out}, 32'd0);
        chk("abort busy", {31'd0, div_busy}, 32'd0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        repeat (40) @(negedge sys_clk);

        run_vec(32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 28, -1, 0, "after reset");
        repeat (3) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
